// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU, one operation in flight, result to rd write port.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_busy,
  output logic            o_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_is_rem;
  logic            r_sa;
  logic            r_sb;
  logic [4:0]      r_addr;
  logic            r_wren;
  logic [4:0]      r_out_addr;
  logic [XLEN-1:0] r_out_data;

  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_result;

  assign w_neg_a = ~i_op[0] & i_rs1_data[XLEN-1];
  assign w_neg_b = ~i_op[0] & i_rs2_data[XLEN-1];
  assign w_mag_a = w_neg_a ? -i_rs1_data : i_rs1_data;
  assign w_mag_b = w_neg_b ? -i_rs2_data : i_rs2_data;

  assign w_div0 = (i_rs2_data == '0);
  assign w_ovf  = ~i_op[0]
                & (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                & (&i_rs2_data);

  // Result for divide-by-zero and signed overflow, no iteration needed
  always_comb begin
    w_spec = '0;
    if (w_div0)
      w_spec = i_op[1] ? i_rs1_data : '1;
    else if (w_ovf)
      w_spec = i_op[1] ? '0 : i_rs1_data;
  end

  // Partial remainder widened by one bit so the compare never overflows
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[XLEN-1:0] - r_div;

  assign w_quo_fix = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_rem_fix = r_sa ? -r_rem : r_rem;
  assign w_result  = r_is_rem ? w_rem_fix : w_quo_fix;

  assign o_busy    = (r_state != S_IDLE);
  assign o_rd_wren = r_wren;
  assign o_rd_addr = r_out_addr;
  assign o_rd_data = r_out_data;

  // Divider FSM: capture, iterate, sign-fix, write strobe
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_is_rem   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_addr     <= '0;
      r_wren     <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_wren  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_wren <= 1'b0;
          if (i_start) begin
            r_is_rem <= i_op[1];
            r_addr   <= i_rd_addr;
            if (w_div0 || w_ovf) begin
              r_quo   <= w_spec;
              r_rem   <= w_spec;
              r_sa    <= 1'b0;
              r_sb    <= 1'b0;
              r_state <= S_FIX;
            end else begin
              r_quo   <= w_mag_a;
              r_rem   <= '0;
              r_div   <= w_mag_b;
              r_sa    <= w_neg_a;
              r_sb    <= w_neg_b;
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN-1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_out_data <= w_result;
          r_out_addr <= r_addr;
          r_wren     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_wren  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and random checks of div_unit
// against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        busy;
  logic        wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int total = 0;
  int bad = 0;
  int wren_cnt = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_flush    (flush),
    .i_op       (op),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_rd_addr  (rd),
    .o_busy     (busy),
    .o_rd_wren  (wren),
    .o_rd_addr  (rd_addr),
    .o_rd_data  (rd_data)
  );

  always @(negedge clk)
    if (wren === 1'b1) wren_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0]) return o[1] ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : a;
    sa = a;
    sb = b;
    return o[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit special(input logic [1:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    return (b == 32'd0) ||
           (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] r,
                        input bit glitch);
    int lat;
    int exp_lat;
    logic [31:0] exp;
    exp = model(o, a, b);
    exp_lat = special(o, a, b) ? 1 : 33;
    @(negedge clk);
    start = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    rd = r;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 41;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (wren === 1'b1) begin
        lat = k;
        break;
      end
      if (glitch && k == 5) begin
        start = 1'b1;
        op = 2'b00;
        rs1 = 32'd50;
        rs2 = 32'd5;
        rd = 5'd9;
      end
      if (glitch && k == 6) start = 1'b0;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rd_data, exp);
    chk({tag, "_addr"}, 32'(rd_addr), 32'(r));
    @(posedge clk);
    #1;
    chk({tag, "_wren_off"}, 32'(wren), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int wc;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    rs1 = '0;
    rs2 = '0;
    rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 1'b0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b0);
    run_op("remu_big_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 5'd4, 1'b0);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd6, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run_op("div_min_1", 2'b00, 32'h8000_0000, 32'd1, 5'd10, 1'b0);
    run_op("rd_x0", 2'b01, 32'd81, 32'd9, 5'd0, 1'b0);
    run_op("glitch", 2'b01, 32'd100, 32'd7, 5'd3, 1'b1);

    wc = wren_cnt;
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    rs1 = 32'd1000;
    rs2 = 32'd3;
    rd = 5'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    rs1 = 32'd77;
    rs2 = 32'd7;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_wren", 32'(wren), 32'd0);
    chk("flush_hold", rd_data, 32'd14);
    repeat (3) @(negedge clk);
    chk("flush_idle", 32'(busy), 32'd0);
    chk("flush_nowr", 32'(wren_cnt - wc), 32'd0);
    run_op("after_flush", 2'b01, 32'd9, 32'd3, 5'd12, 1'b0);

    wc = wren_cnt;
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    rs1 = 32'd12345;
    rs2 = 32'd17;
    rd = 5'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_wren", 32'(wren), 32'd0);
    chk("mrst_addr", 32'(rd_addr), 32'd0);
    chk("mrst_data", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_nowr", 32'(wren_cnt - wc), 32'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), ro, ra, rb,
             5'($urandom_range(0, 31)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
